// File: rtl/fp16_vec_accumulator.sv
// Multi-lane FP16 sum (optionally max) reduction engine with start/done control.
// Optional feature macro: ACC_MAX_MODE_EN adds the `mode` port and FP16 max combiners.

// Combinational FP16 adder: round-to-nearest-even, full subnormal support,
// canonical NaN 16'h7E00 for NaN inputs and inf - inf.
module new_fp16_add (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);
   logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, sticky, rnd;
   logic [15:0] x, z;
   logic [4:0]  ex, ez, d, lz, sh;
   logic [10:0] mx, mz;
   logic [40:0] z_sh;
   logic [13:0] gx, gz, n;
   logic [14:0] s, mag;
   logic [5:0]  e;

   always_comb begin
      a_nan   = (&a[14:10]) && (|a[9:0]);
      b_nan   = (&b[14:10]) && (|b[9:0]);
      a_inf   = (&a[14:10]) && !(|a[9:0]);
      b_inf   = (&b[14:10]) && !(|b[9:0]);
      swap    = b[14:0] > a[14:0];
      x       = swap ? b : a;
      z       = swap ? a : b;
      ex      = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
      ez      = (z[14:10] == 5'd0) ? 5'd1 : z[14:10];
      mx      = {|x[14:10], x[9:0]};
      mz      = {|z[14:10], z[9:0]};
      d       = ex - ez;
      // Align the smaller operand keeping guard/round bits and a sticky OR
      z_sh    = {mz, 30'd0} >> d;
      sticky  = |z_sh[26:0];
      gx      = {mx, 3'b000};
      gz      = {z_sh[40:28], z_sh[27] | sticky};
      eff_sub = x[15] ^ z[15];
      s       = eff_sub ? ({1'b0, gx} - {1'b0, gz}) : ({1'b0, gx} + {1'b0, gz});
      lz      = 5'd14;
      for (int i = 0; i < 14; i++)
         if (s[i]) lz = 5'(13 - i);
      sh      = 5'd0;
      if (s[14]) begin
         n = {s[14:2], s[1] | s[0]};
         e = {1'b0, ex} + 6'd1;
      end else begin
         // Stop normalising at the minimum exponent: result becomes subnormal
         sh = (lz < ex - 5'd1) ? lz : ex - 5'd1;
         n  = s[13:0] << sh;
         e  = {1'b0, ex} - {1'b0, sh};
      end
      rnd = n[2] & (n[1] | n[0] | n[3]);
      // Rounding carry ripples into the exponent field (subnormal->normal, overflow->inf)
      mag = {(n[13] ? e[4:0] : 5'd0), n[12:3]} + {14'd0, rnd};
      if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) y = 16'h7E00;
      else if (a_inf)                                            y = a;
      else if (b_inf)                                            y = b;
      else if (s == 15'd0)                                       y = {a[15] & b[15], 15'd0};
      else if (e >= 6'd31)                                       y = {x[15], 15'h7C00};
      else                                                       y = {x[15], mag};
   end
endmodule

module fp16_vec_accumulator #(
   parameter int DATA_WIDTH = 16,
   parameter int DATA_CNT   = 64,
   parameter int LANES      = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              clear,
`ifdef ACC_MAX_MODE_EN
   input  logic                              mode,
`endif
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [LANES-1:0][DATA_WIDTH-1:0]  in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATA_WIDTH-1:0]             result,
   output logic                              busy
);
   localparam int BEATS = DATA_CNT / LANES;
   localparam int CW    = $clog2(BEATS + 1);
   localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;

   if (DATA_WIDTH != 16) begin : g_bad_width
      $error("fp16_vec_accumulator: DATA_WIDTH must be 16");
   end
   if ((DATA_CNT % LANES) != 0 || DATA_CNT < LANES || LANES < 1 || LANES > 16) begin : g_bad_cnt
      $error("fp16_vec_accumulator: illegal DATA_CNT/LANES");
   end

   typedef enum logic [1:0] {IDLE, ACCUM, REDUCE, DONE} state_t;

   state_t                            st_q, st_d;
   logic [CW-1:0]                     cnt_q, cnt_d;
   logic [IW-1:0]                     fold_q, fold_d;
   logic [LANES-1:0][DATA_WIDTH-1:0]  acc_q, acc_d, lane_sum, lane_res;
   logic [DATA_WIDTH-1:0]             fold_sum, fold_res, ident;
   logic                              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic                              accept;

`ifdef ACC_MAX_MODE_EN
   logic mode_q, mode_d;

   // Sign-magnitude max; signed zeros tie and keep the accumulator (left operand)
   function automatic logic [15:0] fp16_max(input logic [15:0] l, input logic [15:0] r);
      logic r_gt;
      if (((&l[14:10]) && (|l[9:0])) || ((&r[14:10]) && (|r[9:0]))) return 16'h7E00;
      if (l[14:0] == 15'd0 && r[14:0] == 15'd0) return l;
      if (l[15] != r[15]) r_gt = l[15];
      else if (l[15])     r_gt = r[14:0] < l[14:0];
      else                r_gt = r[14:0] > l[14:0];
      return r_gt ? r : l;
   endfunction
`endif

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      new_fp16_add u_add (.a(acc_q[k]), .b(in_data[k]), .y(lane_sum[k]));
`ifdef ACC_MAX_MODE_EN
      assign lane_res[k] = mode_q ? fp16_max(acc_q[k], in_data[k]) : lane_sum[k];
`else
      assign lane_res[k] = lane_sum[k];
`endif
   end

   new_fp16_add u_fold (.a(acc_q[0]), .b(acc_q[fold_q]), .y(fold_sum));

`ifdef ACC_MAX_MODE_EN
   assign fold_res = mode_q ? fp16_max(acc_q[0], acc_q[fold_q]) : fold_sum;
   assign ident    = mode ? 16'hFC00 : 16'h0000;
`else
   assign fold_res = fold_sum;
   assign ident    = 16'h0000;
`endif

   assign accept = in_valid & in_ready_q;

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      fold_d = fold_q;
      acc_d  = acc_q;
`ifdef ACC_MAX_MODE_EN
      mode_d = mode_q;
`endif
      if (clear) begin
         st_d = IDLE;
      end else begin
         case (st_q)
            IDLE: if (start) begin
               st_d  = ACCUM;
               cnt_d = '0;
               for (int k = 0; k < LANES; k++) acc_d[k] = ident;
`ifdef ACC_MAX_MODE_EN
               mode_d = mode;
`endif
            end
            ACCUM: if (accept) begin
               acc_d  = lane_res;
               cnt_d  = cnt_q + 1'b1;
               fold_d = IW'(1);
               if (cnt_q == CW'(BEATS - 1)) st_d = (LANES > 1) ? REDUCE : DONE;
            end
            REDUCE: begin
               acc_d[0] = fold_res;
               fold_d   = fold_q + 1'b1;
               if (fold_q == IW'(LANES - 1)) st_d = DONE;
            end
            DONE: if (out_ready) st_d = IDLE;
            default: st_d = IDLE;
         endcase
      end
      in_ready_d  = (st_d == ACCUM);
      out_valid_d = (st_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q        <= IDLE;
         cnt_q       <= '0;
         fold_q      <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef ACC_MAX_MODE_EN
         mode_q      <= 1'b0;
`endif
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         fold_q      <= fold_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef ACC_MAX_MODE_EN
         mode_q      <= mode_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = acc_q[0];
   assign busy      = (st_q != IDLE);
endmodule

// File: doc/fp16_vec_accumulator.md
# fp16_vec_accumulator

Multi-lane FP16 reduction engine for the SFU. It consumes a stream of `DATA_CNT` half-precision values, `LANES` values per beat, over a valid/ready handshake and keeps one partial accumulator per lane. When the stream ends it folds the lane partials into a single scalar and presents that scalar on a valid/ready output. It replaces free-running, fixed-width accumulation with explicit start/done control, backpressure and parallel lanes, and feeds softmax/layernorm normalisation paths.

## Interface
Parameters:
- `DATA_WIDTH`, 16: element width; only 16 (FP16) is legal, elaboration error otherwise.
- `DATA_CNT`, 64: elements per reduction; must be a multiple of `LANES`, ≥ `LANES`.
- `LANES`, 4: elements per input beat and number of lane accumulators; 1..16.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request to begin a reduction; honoured only in IDLE.
- `clear` in 1: synchronous abort; returns the block to IDLE from any state.
- `mode` in 1: 0 = sum, 1 = max; sampled on an accepted `start`. Present only with `ACC_MAX_MODE_EN`.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat.
- `in_data` in `LANES`x`DATA_WIDTH`: beat elements; lane k is element `beat*LANES+k`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out `DATA_WIDTH`: reduced FP16 value.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, ACCUM, REDUCE, DONE.
- **IDLE**
  - `start=1` loads every lane accumulator with the identity value, clears the beat counter, latches `mode` and moves to ACCUM.
  - Identity is +0 (16'h0000) for sum and −inf (16'hFC00) for max.
- **ACCUM**
  - `in_ready=1`.
  - On each accepted beat (`in_valid && in_ready`), lane k updates `acc[k] <= op(acc[k], in_data[k])`, where op is a `new_fp16_add` instance (one per lane) or an FP16 max.
  - The beat counter increments on every accepted beat. Its width is `$clog2(DATA_CNT/LANES+1)`.
  - On the accepted beat numbered `DATA_CNT/LANES` (final beat): go to REDUCE if `LANES>1`, else go to DONE.
- **REDUCE**
  - A single extra combiner folds `acc[0] <= op(acc[0], acc[k])` for k = 1..`LANES-1`, one k per cycle.
  - The state lasts exactly `LANES-1` cycles, then moves to DONE.
  - Fold order is fixed (ascending k), so results are bit-reproducible.
- **DONE**
  - `out_valid=1` and `result=acc[0]`, both held stable until `out_ready`.
  - The `out_valid && out_ready` handshake returns the block to IDLE.
- **FP16 max**
  - Compare as sign-magnitude.
  - If either operand is NaN, the result is 16'h7E00.
  - −0 and +0 are treated as equal; the left operand (the accumulator) is kept.
- **Sum**: numerics are exactly those of `new_fp16_add`. No extra rounding or flushing is added.
- **Precedence**: `rst` > `clear` > all other events.
  - `clear` in ACCUM discards the beat presented in the same cycle.
  - `start` outside IDLE is ignored; `start` and `clear` together leave the block in IDLE.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `busy=0`, `result=16'h0000`, state=IDLE, counter=0, all accumulators 16'h0000.
- `start` accepted at cycle t → `in_ready=1` from t+1.
- Final beat accepted at cycle T → `out_valid=1` from T+`LANES` (with `LANES=1`, from T+1).
- Minimum start-to-result latency is `DATA_CNT/LANES + LANES` cycles with no input stalls.
- `in_ready` is purely a function of state, with no combinational path from `in_valid`. `out_valid` and `result` are registered.
- Stalls: `in_valid=0` gaps in ACCUM hold all state. `out_ready=0` in DONE holds `result` indefinitely.
- Back-to-back operation: the earliest next `start` is accepted in the cycle after the output handshake.

## Configuration
- `ACC_MAX_MODE_EN` defined:
  - The `mode` port exists.
  - Per-lane and fold combiners are muxes between the adder and the FP16 max comparator.
- Not defined:
  - The `mode` port is absent, and the block is sum-only with identity 16'h0000.
  - No max logic is instantiated.

## Test plan
- Sum, `DATA_CNT=64`, `LANES=4`: 64 × 16'h3C00 (1.0) with no stalls → `result=16'h5400` (64.0), `out_valid` exactly 20 cycles after `start`.
- Backpressure: same stream with random `in_valid` gaps, plus `out_ready` held low 10 cycles → `result` stays 16'h5400 and stable while `out_valid=1`. Exactly one handshake, then IDLE.
- Mixed values (`LANES=4`): beat 0 = {16'h4000, 16'h3800, 16'hBC00, 16'h0000}, remaining 15 beats zero → `result=16'h3E00` (1.5).
- Max mode (`ACC_MAX_MODE_EN`): 64 elements all 16'hC000 (−2.0) except element 37 = 16'h4200 (3.0) → `result=16'h4200`. Inject one 16'h7E00 element → `result=16'h7E00`.
- Abort: `clear` after 5 beats → `busy=0` next cycle and `out_valid` never asserts. A fresh reduction of 64 × 16'h3C00 then yields 16'h5400.
- Async reset mid-REDUCE: assert `rst` between clock edges → all outputs at reset values immediately. `start` is ignored while `rst=1`.
